// File: rtl/tdd_frame_timer.sv
// tdd_frame_timer: sample-clock TDD frame counter producing ien/oen/sync qualifiers
// with shadowed per-frame configuration and a one-shot frame-length adjust.
module tdd_frame_timer #(
    parameter int CW = 24
) (
    input  logic          Sclk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          tddmode,
    input  logic [CW-1:0] frame_len,
    input  logic [CW-1:0] tstart,
    input  logic [CW-1:0] tend,
    input  logic [CW-1:0] rstart,
    input  logic [CW-1:0] rend,
    input  logic [CW-1:0] frame_adj,
    input  logic          adj_req_tgl,
    output logic          adj_pending,
    output logic [CW-1:0] frame_cnt,
    output logic          running,
    output logic          ien,
    output logic          oen,
    output logic          sync
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, len_q, len_d;
    logic [CW-1:0] ts_q, ts_d, te_q, te_d, rs_q, rs_d, re_q, re_d;
    logic          tdd_q, tdd_d, pend_q, pend_d;
    logic          sync_q, sync_d, ien_q, ien_d, oen_q, oen_d;
    logic [2:0]    tgl_q;
    logic          edge_det, load;
    logic signed [CW+1:0] adj_sum;
    logic [CW-1:0] adj_len, base_len;

    function automatic logic in_win(input logic [CW-1:0] s, input logic [CW-1:0] e, input logic [CW-1:0] c);
        return (s < e) ? (c >= s && c < e) : (s > e) ? (c >= s || c < e) : 1'b0;
    endfunction

    always_comb begin
        edge_det = tgl_q[1] ^ tgl_q[2];
        load     = en && (state_q == IDLE || cnt_q == len_q - CW'(1));
        // two guard bits keep the signed sum exact before clamping to [2, 2^CW-1]
        adj_sum  = $signed({2'b00, frame_len}) + $signed({{2{frame_adj[CW-1]}}, frame_adj});
        adj_len  = (adj_sum[CW+1] || adj_sum[CW:1] == '0) ? CW'(2) : adj_sum[CW] ? '1 : adj_sum[CW-1:0];
        base_len = (frame_len[CW-1:1] == '0) ? CW'(2) : frame_len;
        state_d  = en ? RUN : IDLE;
        cnt_d    = (load || !en) ? '0 : cnt_q + CW'(1);
        len_d    = load ? (pend_q ? adj_len : base_len) : len_q;
        ts_d     = load ? tstart : ts_q;
        te_d     = load ? tend : te_q;
        rs_d     = load ? rstart : rs_q;
        re_d     = load ? rend : re_q;
        tdd_d    = load ? tddmode : tdd_q;
        pend_d   = edge_det || (pend_q && !load);
        sync_d   = load;
        oen_d    = en && (!tdd_d || in_win(ts_d, te_d, cnt_d));
        ien_d    = en && (!tdd_d || in_win(rs_d, re_d, cnt_d));
    end

    always_ff @(posedge Sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            ts_q    <= '0;
            te_q    <= '0;
            rs_q    <= '0;
            re_q    <= '0;
            tdd_q   <= 1'b0;
            pend_q  <= 1'b0;
            sync_q  <= 1'b0;
            ien_q   <= 1'b0;
            oen_q   <= 1'b0;
            tgl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ts_q    <= ts_d;
            te_q    <= te_d;
            rs_q    <= rs_d;
            re_q    <= re_d;
            tdd_q   <= tdd_d;
            pend_q  <= pend_d;
            sync_q  <= sync_d;
            ien_q   <= ien_d;
            oen_q   <= oen_d;
            tgl_q   <= {tgl_q[1:0], adj_req_tgl};
        end
    end

    assign running     = (state_q == RUN);
    assign frame_cnt   = cnt_q;
    assign adj_pending = pend_q;
    assign sync        = sync_q;
    assign ien         = ien_q;
    assign oen         = oen_q;
endmodule

// File: tb/tb_tdd_frame_timer.sv
// tb_tdd_frame_timer: directed scenarios plus randomized traffic checked against
// a cycle-level behavioural model of the frame timer.
module tb_tdd_frame_timer;
    localparam int CW = 24;
    localparam longint M = longint'(1) << CW;

    logic          Sclk = 1'b0, rst_n = 1'b0, en = 1'b0, tddmode = 1'b0, adj_req_tgl = 1'b0;
    logic [CW-1:0] frame_len = '0, tstart = '0, tend = '0, rstart = '0, rend = '0, frame_adj = '0;
    logic          adj_pending, running, ien, oen, sync;
    logic [CW-1:0] frame_cnt;
    int            checks = 0, errors = 0;

    always #5 Sclk = ~Sclk;

    tdd_frame_timer #(.CW(CW)) dut (
        .Sclk(Sclk), .rst_n(rst_n), .en(en), .tddmode(tddmode), .frame_len(frame_len),
        .tstart(tstart), .tend(tend), .rstart(rstart), .rend(rend), .frame_adj(frame_adj),
        .adj_req_tgl(adj_req_tgl), .adj_pending(adj_pending), .frame_cnt(frame_cnt),
        .running(running), .ien(ien), .oen(oen), .sync(sync)
    );

    bit     m_run = 0, m_pend = 0, m_tdd = 0, p1 = 0, p2 = 0, p3 = 0;
    longint m_cnt = 0, m_len = 0, m_ts = 0, m_te = 0, m_rs = 0, m_re = 0;

    // window membership as modular distance from the start: covers plain, wrapped and empty windows
    function automatic bit in_win(longint s, longint e, longint c);
        return ((c - s + M) % M) < ((e - s + M) % M);
    endfunction

    always @(posedge Sclk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_pend = 0; m_tdd = 0; p1 = 0; p2 = 0; p3 = 0;
            m_cnt = 0; m_len = 0; m_ts = 0; m_te = 0; m_rs = 0; m_re = 0;
        end else begin : step
            bit     edg, load;
            longint sum;
            edg  = (p2 != p3);
            load = en && (!m_run || m_cnt == m_len - 1);
            if (load) begin
                sum   = longint'(frame_len) + longint'($signed(frame_adj));
                m_len = m_pend ? (sum < 2 ? 2 : (sum > M - 1 ? M - 1 : sum))
                               : (longint'(frame_len) < 2 ? 2 : longint'(frame_len));
                m_ts = tstart; m_te = tend; m_rs = rstart; m_re = rend; m_tdd = tddmode;
            end
            m_pend = edg || (m_pend && !load);
            m_cnt  = (!en || load) ? 0 : m_cnt + 1;
            m_run  = en;
            p3 = p2; p2 = p1; p1 = adj_req_tgl;
        end
    end

    function automatic logic [CW+4:0] obs();
        return {running, sync, ien, oen, adj_pending, frame_cnt};
    endfunction

    function automatic logic [CW+4:0] expv();
        return {m_run, m_run && m_cnt == 0, m_run && (!m_tdd || in_win(m_rs, m_re, m_cnt)),
                m_run && (!m_tdd || in_win(m_ts, m_te, m_cnt)), m_pend, CW'(m_cnt)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge Sclk);
        checks++; if (obs() !== '0) begin errors++; $display("FAIL reset_state got=%h want=0", obs()); end
        checks++; if (obs() !== expv()) begin errors++; $display("FAIL reset_model got=%h want=%h", obs(), expv()); end
        rst_n = 1'b1;
        @(negedge Sclk);
    endtask

    task automatic test_start();
        int syncs = 0;
        frame_len = 10; tddmode = 1; tstart = 2; tend = 5; rstart = 6; rend = 9; en = 1;
        @(negedge Sclk);
        checks++; if ({running, sync, frame_cnt} !== {2'b11, CW'(0)}) begin errors++; $display("FAIL start_first run/sync/cnt got=%b%b/%0d want=11/0", running, sync, frame_cnt); end
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge Sclk);
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL start_model got=%h want=%h", obs(), expv()); end
            checks++; if ({oen, ien} !== {frame_cnt >= 2 && frame_cnt <= 4, frame_cnt >= 6 && frame_cnt <= 8}) begin errors++; $display("FAIL start_windows cnt=%0d got oen/ien=%b%b", frame_cnt, oen, ien); end
            syncs += int'(sync);
        end
        checks++; if (syncs != 3) begin errors++; $display("FAIL start_sync_period got=%0d want=3", syncs); end
    endtask

    task automatic test_wrap_window();
        int n = 0;
        frame_len = 8; rstart = 6; rend = 2; tstart = 3; tend = 3;
        do begin @(negedge Sclk); n++;
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL wrap_wait_model got=%h want=%h", obs(), expv()); end
        end while (!sync && n < 20);
        for (int i = 0; i < 24; i++) begin
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL wrap_model got=%h want=%h", obs(), expv()); end
            checks++; if ({oen, ien} !== {1'b0, frame_cnt >= 6 || frame_cnt < 2}) begin errors++; $display("FAIL wrap_windows cnt=%0d got oen/ien=%b%b", frame_cnt, oen, ien); end
            @(negedge Sclk);
        end
    endtask

    task automatic test_adjust(input int adj, input int exp_len);
        int n = 0;
        int tgt = int'($urandom_range(10, 80));
        frame_len = 100; frame_adj = CW'(adj);
        do begin @(negedge Sclk); n++;
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL adj_wait_model got=%h want=%h", obs(), expv()); end
        end while (!(sync && m_len == 100) && n < 250);
        n = 0;
        while (int'(frame_cnt) != tgt && n < 120) begin @(negedge Sclk); n++; end
        adj_req_tgl = ~adj_req_tgl;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Sclk);
            checks++; if (adj_pending !== (i == 3)) begin errors++; $display("FAIL adj_latency cycle=%0d got=%b want=%b", i, adj_pending, i == 3); end
        end
        n = 0;
        do begin @(negedge Sclk); n++;
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL adj_model got=%h want=%h", obs(), expv()); end
        end while (!sync && n < 150);
        checks++; if ({sync, adj_pending} !== 2'b10) begin errors++; $display("FAIL adj_clear sync/pending got=%b%b want=10", sync, adj_pending); end
        for (int f = 0; f < 2; f++) begin
            n = 0;
            do begin @(negedge Sclk); n++;
                checks++; if (obs() !== expv()) begin errors++; $display("FAIL adj_frame_model got=%h want=%h", obs(), expv()); end
            end while (!sync && n < 300);
            checks++; if (n != (f == 0 ? exp_len : 100)) begin errors++; $display("FAIL adj_frame_len frame=%0d got=%0d want=%0d", f, n, f == 0 ? exp_len : 100); end
        end
    endtask

    task automatic test_midframe_fdd();
        int n = 0;
        frame_len = 10;
        do begin @(negedge Sclk); n++; end while (!(sync && m_len == 10) && n < 250);
        n = 0;
        while (frame_cnt != 4 && n < 20) begin @(negedge Sclk); n++; end
        frame_len = 20;
        n = 0;
        do begin @(negedge Sclk); n++;
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL mid_model got=%h want=%h", obs(), expv()); end
        end while (!sync && n < 40);
        checks++; if (n != 6) begin errors++; $display("FAIL mid_old_wrap got=%0d want=6", n); end
        repeat (7) @(negedge Sclk);
        tddmode = 0;
        n = 7;
        do begin @(negedge Sclk); n++;
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL fdd_wait_model got=%h want=%h", obs(), expv()); end
        end while (!sync && n < 60);
        checks++; if (n != 20) begin errors++; $display("FAIL mid_new_len got=%0d want=20", n); end
        for (int i = 0; i < 20; i++) begin
            checks++; if ({ien, oen} !== 2'b11) begin errors++; $display("FAIL fdd_windows cnt=%0d got ien/oen=%b%b want=11", frame_cnt, ien, oen); end
            @(negedge Sclk);
        end
    endtask

    task automatic test_stop_restart();
        int n = 0;
        while (frame_cnt != 5 && n < 40) begin @(negedge Sclk); n++; end
        en = 0;
        @(negedge Sclk);
        checks++; if ({running, ien, oen, sync, frame_cnt} !== '0) begin errors++; $display("FAIL stop got run/ien/oen/sync=%b%b%b%b cnt=%0d want all 0", running, ien, oen, sync, frame_cnt); end
        repeat (3) begin @(negedge Sclk);
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL idle_model got=%h want=%h", obs(), expv()); end
        end
        en = 1;
        @(negedge Sclk);
        checks++; if ({running, sync, frame_cnt} !== {2'b11, CW'(0)}) begin errors++; $display("FAIL restart got run/sync=%b%b cnt=%0d want=11/0", running, sync, frame_cnt); end
    endtask

    task automatic test_async_reset();
        tddmode = 1;
        repeat (4) @(negedge Sclk);
        adj_req_tgl = ~adj_req_tgl;
        repeat (3) @(negedge Sclk);
        checks++; if (adj_pending !== 1'b1) begin errors++; $display("FAIL areset_pre_pending got=%b want=1", adj_pending); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (obs() !== '0) begin errors++; $display("FAIL areset_clear got=%h want=0", obs()); end
        @(negedge Sclk);
        rst_n = 1'b1;
        repeat (3) begin @(negedge Sclk);
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL areset_model got=%h want=%h", obs(), expv()); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            @(negedge Sclk);
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL rand_model i=%0d got=%h want=%h", i, obs(), expv()); end
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 9) == 0) begin
                frame_len = CW'($urandom_range(0, 14));
                tstart = CW'($urandom_range(0, 14)); tend = CW'($urandom_range(0, 14));
                rstart = CW'($urandom_range(0, 14)); rend = CW'($urandom_range(0, 14));
                tddmode = 1'($urandom_range(0, 1));
                frame_adj = CW'(int'($urandom_range(0, 24)) - 12);
            end
            if ($urandom_range(0, 15) == 0) adj_req_tgl = ~adj_req_tgl;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_wrap_window();
        test_adjust(-3, 97);
        test_adjust(-200, 2);
        test_midframe_fdd();
        test_stop_restart();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdd_frame_timer.md
Name: tdd_frame_timer

Overview:
- Sample-clock-domain TDD frame timer; sits directly upstream of the AXI2S stream bridge.
- Generates the `ien` (RX capture window), `oen` (TX playout window) and `sync` (frame start) qualifiers that gate AXI2S `Sin`/`Sout` transfers.
- Takes frame length, window and one-shot frame-adjust configuration from the AXI2SREG register space.
- Returns `adj_pending` and the live frame count for software readback.

Parameters:
- CW, 24: width of frame counter, frame_len, window bounds and frame_adj.

Ports:
- Sclk  in  1  sample clock; every register in the block is clocked on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  timer enable; level, static relative to Sclk.
- tddmode  in  1  1 = TDD windows active; 0 = FDD (ien = oen = 1 while running).
- frame_len  in  CW  frame length in Sclk cycles.
- tstart  in  CW  TX window start count.
- tend  in  CW  TX window end count, exclusive.
- rstart  in  CW  RX window start count.
- rend  in  CW  RX window end count, exclusive.
- frame_adj  in  CW  signed one-shot length adjustment.
- adj_req_tgl  in  1  toggles once per adjust request; driven from the register clock domain.
- adj_pending  out  1  adjust requested but not yet applied.
- frame_cnt  out  CW  current position in the frame.
- running  out  1  timer active.
- ien  out  1  RX window qualifier to AXI2S.
- oen  out  1  TX window qualifier to AXI2S.
- sync  out  1  single-cycle frame-start pulse.

Behaviour:
- **Reset.** All outputs 0; internal state IDLE; shadow registers 0; synchronizer flops 0. rst_n assertion mid-frame clears everything immediately.
- **States.**
  - IDLE: frame_cnt = 0; ien = oen = sync = 0.
  - IDLE -> RUN on the first cycle en = 1. Next cycle: frame_cnt = 0, sync = 1, shadow load.
  - RUN -> IDLE on the cycle after en = 0, from any count; no frame completion.
- **Counter.**
  - In RUN, frame_cnt increments by 1 each cycle.
  - At frame_cnt == len_s - 1 it wraps to 0 and performs a shadow load.
- **Shadow load** (on every cycle where frame_cnt becomes 0):
  - Capture tstart, tend, rstart, rend and tddmode.
  - len_s = max(frame_len, 2).
  - If adj pending: len_s = frame_len + sign_extend(frame_adj), clamped to [2, 2^CW - 1], and pending clears on that same cycle.
  - Configuration changes mid-frame take effect at the next frame start only.
- **Adjust request.**
  - adj_req_tgl passes through a 2-flop synchronizer plus an edge-detect flop.
  - Any edge sets pending; pending is visible on adj_pending 3 cycles after the toggle.
  - Edge and shadow load in the same cycle: the load uses the old pending value, and the new request stays pending for the next frame.
  - A second edge while pending is already set is absorbed.
  - Request while IDLE: stays pending until the first frame start.
- **Window decode** (registered, aligned with frame_cnt).
  - For a window (s, e) at count c:
    - s < e: active when s <= c < e.
    - s > e (wrap): active when c >= s or c < e.
    - s == e: never active.
  - oen = TX window (tstart, tend); ien = RX window (rstart, rend).
  - When tddmode_s = 0, ien = oen = 1 throughout RUN.
  - sync = 1 exactly when in RUN and frame_cnt == 0.
  - running = 1 in RUN.
- **Timing.** Outputs change only on Sclk edges; zero combinational paths from inputs to outputs.

Test Plan:
1. **Reset and start.** rst_n low, then high; en = 1 with frame_len = 10, tddmode = 1, tstart = 2, tend = 5, rstart = 6, rend = 9.
   - First RUN cycle: frame_cnt = 0, sync = 1.
   - oen high at counts 2..4; ien high at counts 6..8.
   - sync pulses every 10 cycles.
2. **Wrapped window and degenerate window.** frame_len = 8, rstart = 6, rend = 2, tstart = tend = 3.
   - ien high at counts 6, 7, 0, 1.
   - oen never asserts.
3. **Frame adjust.** frame_len = 100, frame_adj = -3, toggle adj_req_tgl mid-frame.
   - adj_pending rises 3 cycles later.
   - The next frame lasts 97 cycles; adj_pending clears at its start.
   - The following frame is back to 100 cycles.
   - Repeat with frame_adj = -200: adjusted frame lasts 2 cycles (clamp).
4. **Mid-frame config change and FDD.**
   - Change frame_len 10 -> 20 at count 4: the current frame still wraps at count 9.
   - Set tddmode = 0: ien = oen = 1 from the next frame start.
5. **Stop and async reset.**
   - Deassert en at count 5: next cycle running = 0, frame_cnt = 0, ien = oen = sync = 0.
   - Re-enable: sync on the first RUN cycle.
   - Assert rst_n mid-frame with adj pending: all outputs and adj_pending go to 0 asynchronously.
